// File: rtl/eth_pkg.sv
// Shared Ethernet types and constants for the TX path.
package eth_pkg;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] ethertype_t;

  localparam ethertype_t ETHERTYPE_ARP  = 16'h0806;
  localparam ethertype_t ETHERTYPE_IPV4 = 16'h0800;
  localparam mac_addr_t  BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    PASS
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority encoder: first requester at or after the pointer,
// wrapping modulo N. Purely combinational.
module rr_arbiter
  import eth_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] index
);

  // Walk the ports in rotated order and stop at the first request
  always_comb begin
    int   cand;
    logic found;
    gnt   = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      // Explicit wrap so non-power-of-two N never selects a missing port
      cand = int'(pointer) + i;
      if (cand >= N) cand = cand - N;
      for (int q = 0; q < N; q++) begin
        if (!found && (q == cand) && req[q]) begin
          gnt[q] = 1'b1;
          index  = IW'(q);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one Ethernet TX stream between
// several protocol engines. One requester owns the output for a whole
// packet; its dst_mac/ethertype are latched on grant and held to tlast.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int AXIS_BYTES = 4,
  parameter int NUM_PORTS  = 2
) (
  input  logic                              clk,
  input  logic                              sresetn,
  output logic [NUM_PORTS-1:0]              axis_i_tready,
  input  logic [NUM_PORTS-1:0]              axis_i_tvalid,
  input  logic [NUM_PORTS-1:0]              axis_i_tlast,
  input  logic [NUM_PORTS*AXIS_BYTES-1:0]   axis_i_tkeep,
  input  logic [NUM_PORTS*AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic [NUM_PORTS*48-1:0]           axis_i_dst_mac,
  input  logic [NUM_PORTS*16-1:0]           axis_i_ethertype,
  input  logic                              axis_o_tready,
  output logic                              axis_o_tvalid,
  output logic                              axis_o_tlast,
  output logic [AXIS_BYTES-1:0]             axis_o_tkeep,
  output logic [AXIS_BYTES*8-1:0]           axis_o_tdata,
  output logic [47:0]                       axis_o_dst_mac,
  output logic [15:0]                       axis_o_ethertype,
  output logic [NUM_PORTS-1:0]              grant_o
);

  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DATA_W = AXIS_BYTES * 8;

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, gidx_q, arb_idx, next_ptr;
  logic [NUM_PORTS-1:0]   grant_q, arb_gnt;
  mac_addr_t              dst_mac_q, arb_mac;
  ethertype_t             ethertype_q, arb_etype;
  logic                   any_req, sel_valid, sel_last, last_hs;
  logic [AXIS_BYTES-1:0]  sel_keep;
  logic [DATA_W-1:0]      sel_data;

  assign any_req  = |axis_i_tvalid;
  assign next_ptr = (gidx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : gidx_q + IDX_W'(1);
  assign last_hs  = (state_q == PASS) && sel_valid && axis_o_tready && sel_last;

  rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (IDX_W)
  ) u_rr (
    .req     (axis_i_tvalid),
    .pointer (ptr_q),
    .gnt     (arb_gnt),
    .index   (arb_idx)
  );

  // Select the owner's beat and the arbitration winner's sideband
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_keep  = '0;
    sel_data  = '0;
    arb_mac   = '0;
    arb_etype = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p]) begin
        sel_valid = axis_i_tvalid[p];
        sel_last  = axis_i_tlast[p];
        sel_keep  = axis_i_tkeep[p*AXIS_BYTES +: AXIS_BYTES];
        sel_data  = axis_i_tdata[p*DATA_W +: DATA_W];
      end
      if (arb_gnt[p]) begin
        arb_mac   = axis_i_dst_mac[p*48 +: 48];
        arb_etype = axis_i_ethertype[p*16 +: 16];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d       = state_q;
    axis_i_tready = '0;
    axis_o_tvalid = 1'b0;
    case (state_q)
      IDLE: if (any_req) state_d = ARB;
      ARB:  state_d = any_req ? PASS : IDLE;
      PASS: begin
        axis_o_tvalid = sel_valid;
        axis_i_tready = grant_q & {NUM_PORTS{axis_o_tready}};
        if (last_hs) state_d = any_req ? ARB : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, round-robin pointer and per-packet sideband latch
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      ptr_q       <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      dst_mac_q   <= '0;
      ethertype_q <= '0;
    end else if (state_q == ARB) begin
      grant_q <= arb_gnt;
      gidx_q  <= arb_idx;
      if (any_req) begin
        dst_mac_q   <= arb_mac;
        ethertype_q <= arb_etype;
      end
    end else if (last_hs) begin
      // The finished port drops to lowest priority for the next round
      grant_q <= '0;
      ptr_q   <= next_ptr;
    end
  end

  assign axis_o_tlast     = sel_last;
  assign axis_o_tkeep     = sel_keep;
  assign axis_o_tdata     = sel_data;
  assign axis_o_dst_mac   = dst_mac_q;
  assign axis_o_ethertype = ethertype_q;
  assign grant_o          = grant_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter with two requesters.
module tb_eth_tx_arbiter;
  import eth_pkg::*;

  localparam int NP = 2;
  localparam int AB = 4;
  localparam int DW = AB * 8;

  logic              clk = 1'b0;
  logic              sresetn = 1'b1;
  logic [NP-1:0]     axis_i_tready;
  logic [NP-1:0]     axis_i_tvalid;
  logic [NP-1:0]     axis_i_tlast;
  logic [NP*AB-1:0]  axis_i_tkeep;
  logic [NP*DW-1:0]  axis_i_tdata;
  logic [NP*48-1:0]  axis_i_dst_mac;
  logic [NP*16-1:0]  axis_i_ethertype;
  logic              axis_o_tready = 1'b1;
  logic              axis_o_tvalid;
  logic              axis_o_tlast;
  logic [AB-1:0]     axis_o_tkeep;
  logic [DW-1:0]     axis_o_tdata;
  logic [47:0]       axis_o_dst_mac;
  logic [15:0]       axis_o_ethertype;
  logic [NP-1:0]     grant_o;

  logic        tv [NP];
  logic        tl [NP];
  logic [3:0]  tk [NP];
  logic [31:0] td [NP];
  mac_addr_t   tm [NP];
  ethertype_t  te [NP];

  bit rand_bp = 1'b0;

  typedef struct {
    logic [31:0]   data;
    logic [3:0]    keep;
    logic          last;
    mac_addr_t     mac;
    ethertype_t    et;
    logic [NP-1:0] grant;
    int            gap;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_hs_cyc = 0;

  eth_tx_arbiter #(.AXIS_BYTES(AB), .NUM_PORTS(NP)) dut (
    .clk              (clk),
    .sresetn          (sresetn),
    .axis_i_tready    (axis_i_tready),
    .axis_i_tvalid    (axis_i_tvalid),
    .axis_i_tlast     (axis_i_tlast),
    .axis_i_tkeep     (axis_i_tkeep),
    .axis_i_tdata     (axis_i_tdata),
    .axis_i_dst_mac   (axis_i_dst_mac),
    .axis_i_ethertype (axis_i_ethertype),
    .axis_o_tready    (axis_o_tready),
    .axis_o_tvalid    (axis_o_tvalid),
    .axis_o_tlast     (axis_o_tlast),
    .axis_o_tkeep     (axis_o_tkeep),
    .axis_o_tdata     (axis_o_tdata),
    .axis_o_dst_mac   (axis_o_dst_mac),
    .axis_o_ethertype (axis_o_ethertype),
    .grant_o          (grant_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      axis_i_tvalid[p]                = tv[p];
      axis_i_tlast[p]                 = tl[p];
      axis_i_tkeep[p*AB +: AB]        = tk[p];
      axis_i_tdata[p*DW +: DW]        = td[p];
      axis_i_dst_mac[p*48 +: 48]      = tm[p];
      axis_i_ethertype[p*16 +: 16]    = te[p];
    end
  end

  // Output backpressure source
  always @(posedge clk) begin
    #1;
    axis_o_tready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard
  always @(negedge clk) begin
    if (sresetn === 1'b1) begin
      check("tready_nongranted", 64'(axis_i_tready & ~grant_o), 64'd0);
      if (axis_o_tvalid && axis_o_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %h expected no beat", axis_o_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("tdata", 64'(axis_o_tdata), 64'(mon_e.data));
          check("tkeep", 64'(axis_o_tkeep), 64'(mon_e.keep));
          check("tlast", 64'(axis_o_tlast), 64'(mon_e.last));
          check("dst_mac", 64'(axis_o_dst_mac), 64'(mon_e.mac));
          check("ethertype", 64'(axis_o_ethertype), 64'(mon_e.et));
          check("grant", 64'(grant_o), 64'(mon_e.grant));
          if (mon_e.gap > 0) check("beat_gap", 64'(cyc - last_hs_cyc), 64'(mon_e.gap));
        end
        last_hs_cyc = cyc;
      end
    end
  end

  function automatic logic [31:0] mk_data(input int k, input int b);
    return 32'hA000_0000 | (32'(k) << 8) | 32'(b);
  endfunction

  function automatic mac_addr_t mac_for(input int k);
    return 48'h0200_0000_0000 + 48'(k);
  endfunction

  function automatic ethertype_t et_for(input int k);
    return (k % 2 == 0) ? ETHERTYPE_IPV4 : ETHERTYPE_ARP;
  endfunction

  task automatic push_pkt(input int p, input int len, input int k, input mac_addr_t m,
                          input ethertype_t t, input int first_gap, input int inner_gap);
    beat_t e;
    for (int b = 0; b < len; b++) begin
      e.data  = mk_data(k, b);
      e.keep  = (b == len - 1) ? 4'h7 : 4'hF;
      e.last  = (b == len - 1);
      e.mac   = m;
      e.et    = t;
      e.grant = NP'(1 << p);
      e.gap   = (b == 0) ? first_gap : inner_gap;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beat(input int p, input logic [31:0] d, input logic [3:0] k, input logic l,
                           input mac_addr_t m, input ethertype_t t, input bit gaps);
    bit hs;
    int n;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 2);
      repeat (g) begin
        tv[p] = 1'b0;
        @(posedge clk); #1;
      end
    end
    tv[p] = 1'b1; td[p] = d; tk[p] = k; tl[p] = l; tm[p] = m; te[p] = t;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 300) begin
      @(negedge clk);
      hs = axis_i_tready[p] && tv[p];
      @(posedge clk); #1;
      n++;
    end
    if (!hs) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: port %0d data %h got no tready expected handshake", p, d);
    end
  endtask

  task automatic send_pkt(input int p, input int len, input int k, input mac_addr_t m,
                          input ethertype_t t, input bit gaps, input bit alt_et);
    for (int b = 0; b < len; b++)
      send_beat(p, mk_data(k, b), (b == len - 1) ? 4'h7 : 4'hF, (b == len - 1), m,
                (alt_et && b >= 2) ? ETHERTYPE_IPV4 : t, gaps && (b > 0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    sresetn = 1'b0;
    @(posedge clk); #1;
    sresetn = 1'b1;
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < NP; p++) begin
      tv[p] = 1'b0; tl[p] = 1'b0; tk[p] = '0; td[p] = '0; tm[p] = '0; te[p] = '0;
    end
    #2 sresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_tvalid", 64'(axis_o_tvalid), 64'd0);
    check("rst_tready", 64'(axis_i_tready), 64'd0);
    check("rst_dst_mac", 64'(axis_o_dst_mac), 64'd0);
    check("rst_ethertype", 64'(axis_o_ethertype), 64'd0);
    @(posedge clk); #1;
    sresetn = 1'b1;

    // Single port, 3-beat packet
    push_pkt(0, 3, 100, 48'h0A0B0C0D0E0F, ETHERTYPE_ARP, -1, 1);
    send_pkt(0, 3, 100, 48'h0A0B0C0D0E0F, ETHERTYPE_ARP, 1'b0, 1'b0);
    tv[0] = 1'b0;
    drain("t1_drained");
    check("t1_grant_after", 64'(grant_o), 64'd0);
    check("t1_tvalid_after", 64'(axis_o_tvalid), 64'd0);

    // Simultaneous requests after reset: port0 then port1 with one bubble
    do_reset();
    push_pkt(0, 3, 10, mac_for(10), et_for(10), -1, 1);
    push_pkt(1, 2, 11, mac_for(11), et_for(11), 2, 1);
    fork
      begin send_pkt(0, 3, 10, mac_for(10), et_for(10), 1'b0, 1'b0); tv[0] = 1'b0; end
      begin send_pkt(1, 2, 11, mac_for(11), et_for(11), 1'b0, 1'b0); tv[1] = 1'b0; end
    join
    drain("t2_drained");

    // Continuous streaming, 8 packets alternating
    for (int k = 0; k < 8; k++)
      push_pkt(k % 2, (k % 3) + 1, k, mac_for(k), et_for(k), (k == 0) ? -1 : 2, 1);
    fork
      begin
        for (int j = 0; j < 4; j++)
          send_pkt(0, ((2*j) % 3) + 1, 2*j, mac_for(2*j), et_for(2*j), 1'b0, 1'b0);
        tv[0] = 1'b0;
      end
      begin
        for (int j = 0; j < 4; j++)
          send_pkt(1, ((2*j+1) % 3) + 1, 2*j+1, mac_for(2*j+1), et_for(2*j+1), 1'b0, 1'b0);
        tv[1] = 1'b0;
      end
    join
    drain("t3_drained");

    // Random backpressure and mid-packet tvalid gaps
    rand_bp = 1'b1;
    for (int k = 20; k < 26; k++)
      push_pkt(k % 2, 2 + (k % 3), k, mac_for(k), et_for(k), -1, -1);
    fork
      begin
        for (int k = 20; k < 26; k += 2)
          send_pkt(0, 2 + (k % 3), k, mac_for(k), et_for(k), 1'b1, 1'b0);
        tv[0] = 1'b0;
      end
      begin
        for (int k = 21; k < 26; k += 2)
          send_pkt(1, 2 + (k % 3), k, mac_for(k), et_for(k), 1'b1, 1'b0);
        tv[1] = 1'b0;
      end
    join
    rand_bp = 1'b0;
    drain("t4_drained");

    // Sideband changes mid-packet must not reach the output
    push_pkt(0, 4, 30, BROADCAST_MAC, ETHERTYPE_ARP, -1, 1);
    send_pkt(0, 4, 30, BROADCAST_MAC, ETHERTYPE_ARP, 1'b0, 1'b1);
    tv[0] = 1'b0;
    drain("t5_drained");

    // Reset during beat 2 of a 4-beat packet on port1
    push_pkt(1, 2, 40, mac_for(40), et_for(40), -1, 1);
    exp_q[exp_q.size() - 1].last = 1'b0;
    exp_q[exp_q.size() - 1].keep = 4'hF;
    send_beat(1, mk_data(40, 0), 4'hF, 1'b0, mac_for(40), et_for(40), 1'b0);
    send_beat(1, mk_data(40, 1), 4'hF, 1'b0, mac_for(40), et_for(40), 1'b0);
    td[1] = mk_data(40, 2);
    #2;
    sresetn = 1'b0;
    #1;
    check("midrst_tvalid", 64'(axis_o_tvalid), 64'd0);
    check("midrst_grant", 64'(grant_o), 64'd0);
    check("midrst_tready", 64'(axis_i_tready), 64'd0);
    tv[1] = 1'b0;
    @(posedge clk); #1;
    sresetn = 1'b1;
    check("midrst_drained", 64'(exp_q.size()), 64'd0);
    push_pkt(0, 1, 41, mac_for(41), et_for(41), -1, 1);
    push_pkt(1, 1, 42, mac_for(42), et_for(42), 2, 1);
    fork
      begin send_pkt(0, 1, 41, mac_for(41), et_for(41), 1'b0, 1'b0); tv[0] = 1'b0; end
      begin send_pkt(1, 1, 42, mac_for(42), et_for(42), 1'b0, 1'b0); tv[1] = 1'b0; end
    join
    drain("t6_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares one Ethernet TX path (eth_framer → axis_packet_fifo_async → gmii_tx_mac) between several protocol engines, e.g. arp_engine plus IP/UDP senders.
- Each requester presents an AXIS payload stream with dst_mac and ethertype sideband.
- The arbiter grants one requester at a time for a whole packet.
- It forwards payload and sideband to the framer, holding the sideband stable for the packet.
- Sits in the clk domain directly upstream of eth_framer.

Parameters:
AXIS_BYTES, 4, payload bytes per beat on every stream.
NUM_PORTS, 2, number of requesters (2..8).

Ports:
clk  input  1  system clock.
sresetn  input  1  asynchronous active-low reset.
axis_i_tready  output  NUM_PORTS  per-port ready.
axis_i_tvalid  input  NUM_PORTS  per-port valid.
axis_i_tlast  input  NUM_PORTS  per-port last.
axis_i_tkeep  input  NUM_PORTS*AXIS_BYTES  per-port keep, port p at [p*AXIS_BYTES +: AXIS_BYTES].
axis_i_tdata  input  NUM_PORTS*AXIS_BYTES*8  per-port data.
axis_i_dst_mac  input  NUM_PORTS*48  per-port destination MAC; valid with the first beat.
axis_i_ethertype  input  NUM_PORTS*16  per-port ethertype; valid with the first beat.
axis_o_tready  input  1  from framer.
axis_o_tvalid  output  1  to framer.
axis_o_tlast  output  1  to framer.
axis_o_tkeep  output  AXIS_BYTES  to framer.
axis_o_tdata  output  AXIS_BYTES*8  to framer.
axis_o_dst_mac  output  48  latched sideband for the current packet.
axis_o_ethertype  output  16  latched sideband for the current packet.
grant_o  output  NUM_PORTS  one-hot current owner; zero when idle.

Behaviour:
- Reset (async assert, sync release via the clock edge):
  - state=IDLE, grant_o=0, rr pointer=0.
  - axis_o_tvalid=0; axis_o_dst_mac=0, axis_o_ethertype=0.
  - all axis_i_tready=0.
- FSM states: IDLE, ARB, PASS.
  - IDLE: if any tvalid is high, go to ARB next cycle. No input is ready.
  - ARB (one cycle): pick the first requesting port at or after the rr pointer, wrapping modulo NUM_PORTS.
    - Register its index into grant_o.
    - Latch its dst_mac and ethertype into axis_o_dst_mac/axis_o_ethertype.
    - Go to PASS.
    - If requests vanished (illegal per AXIS, but tolerated), return to IDLE with grant_o=0.
  - PASS: combinational mux of the granted port.
    - axis_o_tvalid = tvalid[g]; axis_o_tlast/tkeep/tdata from port g.
    - axis_i_tready[g] = axis_o_tready; all other ports' tready = 0.
    - On a handshake with tlast: rr pointer ← g+1 (mod NUM_PORTS), grant_o ← 0, state ← IDLE, or ← ARB directly if any tvalid is high that cycle.
- Arbitration latency: first output beat valid no earlier than 2 cycles after tvalid rises from IDLE, or 1 cycle after the previous tlast in back-to-back operation. One bubble cycle between packets.
- Sideband is constant from the first beat through tlast, and is not re-sampled mid-packet.
- No data buffering; the block adds zero beats and drops zero beats.
- Fairness: a port requesting continuously is granted within NUM_PORTS packets.
- A port whose tvalid drops mid-packet keeps the grant; the output stalls. No timeout.
- Simultaneous tlast handshake and new requests: the pointer update happens before selection. The just-finished port has lowest priority.
- Single-beat packets (tvalid, tlast on beat 0) are legal.
- Reset mid-packet: all outputs return to reset values immediately. The partial packet is the downstream packet FIFO's concern.
- grant_o index width: $clog2(NUM_PORTS); handle NUM_PORTS not a power of two with explicit wrap.

Decomposition:
- eth_pkg:
  - mac_addr_t (48 bits), ethertype_t (16 bits).
  - ETHERTYPE_ARP=16'h0806, ETHERTYPE_IPV4=16'h0800.
  - BROADCAST_MAC=48'hFFFFFFFFFFFF.
- Sub-module rr_arbiter (parameter N):
  - inputs req, pointer.
  - outputs one-hot gnt and index; purely combinational rotate-priority-encode.
- eth_tx_arbiter instantiates one rr_arbiter plus the FSM and mux.

Test Plan:
- Single port, NUM_PORTS=2: port0 sends 3-beat packet, dst_mac=48'h0A0B0C0D0E0F, ethertype=16'h0806.
  - Output: 3 beats identical.
  - Sideband stable for all 3 beats.
  - grant_o=2'b01 during the packet, 0 afterwards.
- Both ports request in the same cycle after reset.
  - Port0 is served first, then port1, with exactly one idle cycle between tlast and port1's first beat.
- Both ports stream continuously for 8 packets.
  - Grants alternate 0,1,0,1…; each port gets 4 packets.
  - Beat count and tdata order are preserved.
- Random axis_o_tready backpressure (50%) plus random tvalid gaps on the granted port.
  - No beat lost or duplicated.
  - Non-granted port's tready stays 0 throughout.
- Sideband change on port0 mid-packet (ethertype 0x0806→0x0800 on beat 2).
  - axis_o_ethertype remains 0x0806 until tlast.
- sresetn asserted during beat 2 of a 4-beat packet.
  - Same cycle: tvalid=0, grant_o=0, all tready=0.
  - After release, a new request is arbitrated from pointer 0.
